// File: rtl/dcmac_0_axis_pkt_chk_buffer_ctx_if.sv
// dcmac_0_axis_pkt_chk_buffer_ctx_if: deposit beat, clear and result bundle for the RX buffer context tracker.
interface dcmac_0_axis_pkt_chk_buffer_ctx_if;
    logic       i_valid;
    logic [2:0] i_id;
    logic [7:0] i_size;
    logic       i_clr;
    logic [2:0] i_clr_id;
    logic       o_valid;
    logic [2:0] o_id;
    logic [7:0] o_wr_idx;
    logic [7:0] o_fill;
    logic       o_blk_done;
    logic [7:0] o_spill;
    logic [7:0] o_blk_seq;
    logic       o_err;

    modport master (
        output i_valid, i_id, i_size, i_clr, i_clr_id,
        input  o_valid, o_id, o_wr_idx, o_fill, o_blk_done, o_spill, o_blk_seq, o_err
    );

    modport slave (
        input  i_valid, i_id, i_size, i_clr, i_clr_id,
        output o_valid, o_id, o_wr_idx, o_fill, o_blk_done, o_spill, o_blk_seq, o_err
    );
endinterface

// File: rtl/dcmac_0_axis_pkt_chk_buffer_ctx.sv
// dcmac_0_axis_pkt_chk_buffer_ctx: per-channel fill/sequence accounting of byte deposits into fixed-size blocks.
module dcmac_0_axis_pkt_chk_buffer_ctx #(
    parameter int BUF_BYTES = 192,
    parameter int MAX_SIZE  = 128
) (
    input logic clk,
    input logic rst,
    dcmac_0_axis_pkt_chk_buffer_ctx_if.slave bus
);
    logic       a_valid;
    logic [2:0] a_id;
    logic [7:0] a_size;
    logic [7:0] fill [8];
    logic [7:0] seq [8];
    logic [7:0] cur_fill, cur_seq, new_fill, new_seq;
    logic [8:0] sum, rem;
    logic       err, done;

    // Oversize beats leave the context untouched but still report it.
    always_comb begin
        cur_fill = fill[a_id];
        cur_seq  = seq[a_id];
        sum      = {1'b0, cur_fill} + {1'b0, a_size};
        rem      = sum - 9'(BUF_BYTES);
        err      = a_size > 8'(MAX_SIZE);
        done     = !err && sum >= 9'(BUF_BYTES);
        new_fill = err ? cur_fill : done ? rem[7:0] : sum[7:0];
        new_seq  = done ? cur_seq + 8'd1 : cur_seq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid        <= 1'b0;
            a_id           <= '0;
            a_size         <= '0;
            for (int k = 0; k < 8; k++) begin
                fill[k] <= '0;
                seq[k]  <= '0;
            end
            bus.o_valid    <= 1'b0;
            bus.o_id       <= '0;
            bus.o_wr_idx   <= '0;
            bus.o_fill     <= '0;
            bus.o_blk_done <= 1'b0;
            bus.o_spill    <= '0;
            bus.o_blk_seq  <= '0;
            bus.o_err      <= 1'b0;
        end else begin
            a_valid     <= bus.i_valid;
            a_id        <= bus.i_id;
            a_size      <= bus.i_size;
            bus.o_valid <= a_valid;
            if (a_valid) begin
                bus.o_id       <= a_id;
                bus.o_wr_idx   <= cur_fill;
                bus.o_fill     <= new_fill;
                bus.o_blk_done <= done;
                bus.o_spill    <= done ? new_fill : 8'd0;
                bus.o_blk_seq  <= cur_seq;
                bus.o_err      <= err;
                if (!err) begin
                    fill[a_id] <= new_fill;
                    seq[a_id]  <= new_seq;
                end
            end
            // Placed last so a clear overrides a same-edge write to that channel.
            if (bus.i_clr) begin
                fill[bus.i_clr_id] <= '0;
                seq[bus.i_clr_id]  <= '0;
            end
        end
    end
endmodule

// File: doc/dcmac_0_axis_pkt_chk_buffer_ctx.md
# dcmac_0_axis_pkt_chk_buffer_ctx

Per-channel receive-side buffer context tracker for the DCMAC AXIS packet checker. It is the counterpart of the generator's buffer context: where the generator drains a 192-byte buffer per channel and requests refills, this block accounts for variable-size byte deposits into a per-channel 192-byte block. It reports the write offset of each deposit, signals block completion, and tracks a per-channel block sequence number. It sits between the RX segment parser (which supplies channel ID and byte count per beat) and the checker's block compare/store logic.

## Interface
Parameters:
- BUF_BYTES, 192, bytes per block; must be >= MAX_SIZE + 1 and <= 255.
- MAX_SIZE, 128, largest legal deposit per beat; any larger i_size is an error.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  deposit beat valid.
- i_id  input  3  channel ID, 0..7.
- i_size  input  8  bytes deposited this beat, 0..MAX_SIZE.
- i_clr  input  1  clear the context of channel i_clr_id (zero fill and seq).
- i_clr_id  input  3  channel to clear.
- o_valid  output  1  result valid.
- o_id  output  3  channel ID of the result.
- o_wr_idx  output  8  byte offset in the current block where this beat's first byte lands (pre-update fill).
- o_fill  output  8  channel fill after this beat.
- o_blk_done  output  1  this beat completed a block.
- o_spill  output  8  bytes of this beat carried into the next block; 0 when o_blk_done=0.
- o_blk_seq  output  8  channel block sequence number before this beat; increments after each completed block.
- o_err  output  1  i_size > MAX_SIZE; context left unchanged.

## Operation
- Context per channel (8 entries): fill[7:0], seq[7:0], held in registers. All entries reset to 0.
- Stage A registers i_valid, i_id, i_size.
- Stage B reads the context of the stage-A ID and computes sum = fill + size as a 9-bit value.
  - sum >= BUF_BYTES: blk_done=1, new_fill = spill = sum - BUF_BYTES, new_seq = seq + 1 (8-bit wrap, 255 -> 0).
  - Otherwise: blk_done=0, new_fill = sum, spill=0, seq unchanged.
  - size > MAX_SIZE: o_err=1, blk_done=0, spill=0, context not written; o_wr_idx, o_fill and o_blk_seq report the unchanged context.
  - size = 0: valid result, no change; o_fill = o_wr_idx.
- On the same edge, stage B writes the context back and registers all outputs.
- Since MAX_SIZE < BUF_BYTES, at most one block completes per beat.
- Clear: i_clr writes fill=0 and seq=0 for i_clr_id at the next edge.
  - If a stage-B beat writes the same ID on that edge, the clear wins.
  - That beat's outputs are still emitted, computed from the pre-clear context.
  - Clear of a different ID does not affect the beat.
- i_valid=0 leaves the context untouched; o_valid deasserts and the other outputs hold their last values.

## Timing
- Latency: i_valid at cycle N -> o_valid at cycle N+2. Full throughput: one beat per cycle, any ID sequence, no stalls.
- Back-to-back beats on the same ID (cycles N, N+1): the second beat sees the context written by the first. There is no read-during-write hazard, because the context write and the next stage-B read are separated by the edge.
- Clear asserted at cycle N: the cleared context is visible to a stage-B beat at cycle N+1.
- Async reset (any time, including mid-stream): immediately zeroes all contexts, pipeline valids and outputs (o_valid, o_id, o_wr_idx, o_fill, o_blk_done, o_spill, o_blk_seq, o_err all 0). Beats in flight are dropped.
- First valid input is accepted at the first edge after rst deasserts.

## Test plan
- ID 0, i_size 64 on three consecutive cycles -> o_wr_idx 0/64/128; o_fill 64/128/0; o_blk_done 0/0/1; o_spill 0/0/0; o_blk_seq 0/0/0, then 1 on the next beat.
- ID 2, size 100 then 100 -> second result: o_wr_idx 100, o_blk_done 1, o_spill 8, o_fill 8.
- Interleave IDs 1,3,1,3 with size 128 each, back-to-back -> on each ID's second beat: o_wr_idx 128, o_blk_done 1, o_spill 64, o_fill 64; the two contexts stay independent.
- ID 5 at fill 10, i_size 129 -> o_err 1, o_fill 10, o_blk_done 0; a following size-1 beat gives o_wr_idx 10, o_fill 11.
- ID 4 at fill 150, size 50 in stage B with i_clr/i_clr_id=4 on the same cycle -> o_blk_done 1, o_spill 8, o_blk_seq old value; the next beat of size 20 sees o_wr_idx 0, o_blk_seq 0.
- Force seq=255 via 255 completed blocks, complete one more -> next o_blk_seq 0.
- Assert rst mid-stream -> all outputs 0 immediately; after release, the first beat on any ID gives o_wr_idx 0.
